// File: rtl/hcordic_pkg.sv
// Shared constants for the hyperbolic CORDIC front end:
// opcodes, CORDIC modes, packet field positions and FP constants.
package hcordic_pkg;

    localparam logic [3:0] OPC_SIN_COS    = 4'd0;
    localparam logic [3:0] OPC_SINH_COSH  = 4'd1;
    localparam logic [3:0] OPC_ARCTAN     = 4'd2;
    localparam logic [3:0] OPC_ARCTANH    = 4'd3;
    localparam logic [3:0] OPC_EXPONENT   = 4'd4;
    localparam logic [3:0] OPC_SQR_ROOT   = 4'd5;
    localparam logic [3:0] OPC_DIVISION   = 4'd6;
    localparam logic [3:0] OPC_TAN        = 4'd7;
    localparam logic [3:0] OPC_TANH       = 4'd8;
    localparam logic [3:0] OPC_NAT_LOG    = 4'd9;
    localparam logic [3:0] OPC_HYPOTENUSE = 4'd10;

    localparam logic [1:0] MODE_LINEAR     = 2'd0;
    localparam logic [1:0] MODE_CIRCULAR   = 2'd1;
    localparam logic [1:0] MODE_HYPERBOLIC = 2'd3;
    localparam logic       OP_ROTATION     = 1'b0;
    localparam logic       OP_VECTORING    = 1'b1;

    localparam int PKT_W  = 108;
    localparam int TAG_HI = 107;
    localparam int TAG_LO = 100;
    localparam int OPC_HI = 99;
    localparam int OPC_LO = 96;
    localparam int Z_HI   = 95;
    localparam int Z_LO   = 64;
    localparam int Y_HI   = 63;
    localparam int Y_LO   = 32;
    localparam int X_HI   = 31;
    localparam int X_LO   = 0;

    localparam logic [31:0] FP_ONE  = 32'h3F800000;
    localparam logic [31:0] FP_MONE = 32'hBF800000;
    localparam logic [7:0]  FP_BIAS = 8'd127;

    // Right shift keeping everything shifted out as a sticky bit in bit 0.
    function automatic logic [26:0] shr_sticky(input logic [26:0] v,
                                               input logic [8:0] d);
        logic [26:0] r;
        logic [26:0] lost;
        if (d >= 9'd26) begin
            r = {26'd0, |v};
        end else begin
            r    = v >> d;
            lost = v << (9'd27 - d);
            r[0] = r[0] | (|lost);
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_lzc27.sv
// Combinational leading-zero counter for a 27-bit significand.
// Returns 27 when the input is all zeros.
module fp_lzc27 (
    input  logic [26:0] din,
    output logic [4:0]  lz
);

    always_comb begin
        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (din[i]) lz = 5'(26 - i);
        end
    end

endmodule

// File: rtl/pre_process_fsl.sv
// Computes a+1 and a-1 (IEEE-754 single) for sqrt/log ahead of Fetch_FSL.
// ROUND_NEAREST_EN selects round-to-nearest-even; otherwise truncation.
module pre_process_fsl
    import hcordic_pkg::*;
#(
    parameter logic [3:0] OPC_SQRT   = 4'd5,
    parameter logic [3:0] OPC_NATLOG = 4'd9
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [107:0] InstructionPacket,
    input  logic         InsValid,
    input  logic         stall,
    output logic         Busy,
    output logic [107:0] InstructionPacket_Processed,
    output logic         ProcessInputReady,
    output logic         InvalidOp
);

    typedef enum logic [2:0] {
        S_IDLE, S_ALIGN, S_ADDSUB, S_NORM, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [7:0]  tag_q;
    logic [3:0]  opc_q;
    logic [31:0] a_q;
    logic [26:0] big_q, small_q, big_d, small_d;
    logic [8:0]  ebig_q, ebig_d;
    logic        lt1_q, lt1_d;
    logic [27:0] sum_q;
    logic [26:0] dif_q;
    logic [31:0] xr_q, yr_q, x_d, y_d;
    logic        inv_q, inv_d;
    logic [107:0] pkt_q;
    logic        pir_q, invop_q;

    logic [3:0]  opc_in;
    logic        accept;
    logic [4:0]  lz;
    logic [8:0]  ea;
    logic [26:0] sn, dn;
    logic [8:0]  se, de;
    logic        dzero, neg;
    logic [30:0] s_mag, d_mag;
    logic        unused_bits;

    assign opc_in = InstructionPacket[OPC_HI:OPC_LO];
    assign accept = (state_q == S_IDLE) && InsValid &&
                    (opc_in == OPC_SQRT || opc_in == OPC_NATLOG);
    assign unused_bits = ^InstructionPacket[Z_HI:Y_LO];

    assign Busy = (state_q != S_IDLE);
    assign InstructionPacket_Processed = pkt_q;
    assign ProcessInputReady = pir_q;
    assign InvalidOp = invop_q;

    // Returns {exp, frac}; m is normalised with bit 26 as the hidden one.
    function automatic logic [30:0] round_pack(input logic [8:0] e,
                                               input logic [26:0] m);
        logic [24:0] mr;
        logic [8:0]  er;
        mr = {1'b0, m[26:3]};
        er = e;
`ifdef ROUND_NEAREST_EN
        if (m[2] & (m[1] | m[0] | m[3])) mr = mr + 25'd1;
        if (mr[24]) begin
            mr = mr >> 1;
            er = er + 9'd1;
        end
`endif
        return {er[7:0], mr[22:0]};
    endfunction

    fp_lzc27 u_lzc (
        .din (dif_q),
        .lz  (lz)
    );

    always_comb begin
        ea      = {1'b0, a_q[30:23]};
        lt1_d   = (ea < {1'b0, FP_BIAS});
        big_d   = {1'b1, a_q[22:0], 3'b000};
        small_d = shr_sticky({1'b1, 26'd0}, ea - {1'b0, FP_BIAS});
        ebig_d  = ea;
        if (lt1_d) begin
            big_d   = {1'b1, 26'd0};
            small_d = shr_sticky({1'b1, a_q[22:0], 3'b000},
                                 {1'b0, FP_BIAS} - ea);
            ebig_d  = {1'b0, FP_BIAS};
        end
    end

    always_comb begin
        neg   = a_q[31];
        sn    = sum_q[27] ? {sum_q[27:2], sum_q[1] | sum_q[0]}
                          : sum_q[26:0];
        se    = ebig_q + {8'd0, sum_q[27]};
        dn    = dif_q << lz;
        de    = ebig_q - {4'd0, lz};
        dzero = (dif_q == 27'd0);
        s_mag = round_pack(se, sn);
        d_mag = dzero ? 31'd0 : round_pack(de, dn);
        // For negative a the roles swap: a+1 = 1-|a|, a-1 = -(|a|+1).
        x_d   = neg ? {~lt1_q & ~dzero, d_mag} : {1'b0, s_mag};
        y_d   = neg ? {1'b1, s_mag} : {lt1_q & ~dzero, d_mag};
        inv_d = neg;
        if (a_q[30:23] == 8'hFF) begin
            x_d   = a_q;
            y_d   = a_q;
            inv_d = 1'b1;
        end else if (a_q[30:23] == 8'h00) begin
            x_d   = FP_ONE;
            y_d   = FP_MONE;
            inv_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (accept) state_d = S_ALIGN;
            S_ALIGN:  state_d = S_ADDSUB;
            S_ADDSUB: state_d = S_NORM;
            S_NORM:   state_d = S_DONE;
            S_DONE:   if (pir_q && !stall) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            tag_q   <= '0;
            opc_q   <= '0;
            a_q     <= '0;
            big_q   <= '0;
            small_q <= '0;
            ebig_q  <= '0;
            lt1_q   <= 1'b0;
            sum_q   <= '0;
            dif_q   <= '0;
            xr_q    <= '0;
            yr_q    <= '0;
            inv_q   <= 1'b0;
            pkt_q   <= '0;
            pir_q   <= 1'b0;
            invop_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                tag_q <= InstructionPacket[TAG_HI:TAG_LO];
                opc_q <= opc_in;
                a_q   <= InstructionPacket[X_HI:X_LO];
            end
            if (state_q == S_ALIGN) begin
                big_q   <= big_d;
                small_q <= small_d;
                ebig_q  <= ebig_d;
                lt1_q   <= lt1_d;
            end
            if (state_q == S_ADDSUB) begin
                sum_q <= {1'b0, big_q} + {1'b0, small_q};
                dif_q <= big_q - small_q;
            end
            if (state_q == S_NORM) begin
                xr_q  <= x_d;
                yr_q  <= y_d;
                inv_q <= inv_d;
            end
            if (state_q == S_DONE && !pir_q) begin
                pkt_q   <= {tag_q, opc_q, 32'h0, yr_q, xr_q};
                pir_q   <= 1'b1;
                invop_q <= inv_q;
            end else if (state_q == S_DONE && !stall) begin
                pir_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pre_process_fsl.sv
// Directed-vector bench for pre_process_fsl: arithmetic, specials,
// rounding, latency, stall/ignore handshakes and async reset.
module tb_pre_process_fsl;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [107:0] InstructionPacket = '0;
    logic         InsValid = 1'b0;
    logic         stall = 1'b0;
    logic         Busy;
    logic [107:0] InstructionPacket_Processed;
    logic         ProcessInputReady;
    logic         InvalidOp;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    pre_process_fsl dut (
        .clock                       (clock),
        .reset                       (reset),
        .InstructionPacket           (InstructionPacket),
        .InsValid                    (InsValid),
        .stall                       (stall),
        .Busy                        (Busy),
        .InstructionPacket_Processed (InstructionPacket_Processed),
        .ProcessInputReady           (ProcessInputReady),
        .InvalidOp                   (InvalidOp)
    );

    task automatic chk(input string tag, input logic [107:0] got,
                       input logic [107:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Present one packet for one accepting edge; returns #1 after it.
    task automatic issue(input logic [7:0] tag, input logic [3:0] opc,
                         input logic [31:0] a);
        @(negedge clock);
        InstructionPacket = {tag, opc, 32'hDEADBEEF, 32'h12345678, a};
        InsValid = 1'b1;
        @(posedge clock);
        #1 InsValid = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [7:0] tag,
                          input logic [3:0] opc, input logic [31:0] a,
                          input logic [31:0] ex, input logic [31:0] ey,
                          input logic einv);
        issue(tag, opc, a);
        chk({name, "_busy"}, Busy, 1);
        repeat (3) @(posedge clock);
        #1 chk({name, "_early"}, ProcessInputReady, 0);
        @(posedge clock);
        #1;
        chk({name, "_rdy"}, ProcessInputReady, 1);
        chk({name, "_pkt"}, InstructionPacket_Processed,
            {tag, opc, 32'h0, ey, ex});
        chk({name, "_inv"}, InvalidOp, einv);
        @(posedge clock);
        #1 chk({name, "_drop"}, {Busy, ProcessInputReady}, 2'b00);
    endtask

    logic [31:0] rx_exp;
    logic [31:0] r2_exp;

    initial begin
`ifdef ROUND_NEAREST_EN
        rx_exp = 32'h4B800002;
        r2_exp = 32'h40000000;
`else
        rx_exp = 32'h4B800001;
        r2_exp = 32'h3FFFFFFF;
`endif
        #1;
        chk("rst_out", {Busy, ProcessInputReady, InvalidOp,
                        InstructionPacket_Processed}, '0);
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b1;

        run_op("sqrt3", 8'hA5, 4'd5, 32'h40400000,
               32'h40800000, 32'h40000000, 1'b0);
        run_op("log_half", 8'h3C, 4'd9, 32'h3F000000,
               32'h3FC00000, 32'hBF000000, 1'b0);
        run_op("one", 8'h01, 4'd5, 32'h3F800000,
               32'h40000000, 32'h00000000, 1'b0);
        run_op("zero", 8'h02, 4'd9, 32'h00000000,
               32'h3F800000, 32'hBF800000, 1'b0);
        run_op("two", 8'h03, 4'd5, 32'h40000000,
               32'h40400000, 32'h3F800000, 1'b0);
        run_op("neg2", 8'h04, 4'd9, 32'hC0000000,
               32'hBF800000, 32'hC0400000, 1'b1);
        run_op("round_big", 8'h05, 4'd5, 32'h4B800001,
               rx_exp, 32'h4B800000, 1'b0);
        run_op("round_sub1", 8'h06, 4'd9, 32'h3F7FFFFF,
               r2_exp, 32'hB3800000, 1'b0);
        run_op("inf", 8'h07, 4'd9, 32'h7F800000,
               32'h7F800000, 32'h7F800000, 1'b1);
        run_op("nan", 8'h08, 4'd5, 32'h7FC00000,
               32'h7FC00000, 32'h7FC00000, 1'b1);

        // Stall holds the finished packet for three cycles.
        stall = 1'b1;
        issue(8'h11, 4'd9, 32'h40400000);
        repeat (4) @(posedge clock);
        #1 chk("stall_rdy", ProcessInputReady, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            chk("stall_hold", ProcessInputReady, 1);
            chk("stall_pkt", InstructionPacket_Processed,
                {8'h11, 4'd9, 32'h0, 32'h40000000, 32'h40800000});
        end
        @(negedge clock) stall = 1'b0;
        @(posedge clock);
        #1 chk("stall_drop", ProcessInputReady, 0);

        // A valid packet while busy is not taken.
        issue(8'h22, 4'd5, 32'h40000000);
        @(negedge clock);
        InstructionPacket = {8'h33, 4'd9, 64'h0, 32'h00000000};
        InsValid = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1 InsValid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1 chk("ign_pkt", InstructionPacket_Processed,
               {8'h22, 4'd5, 32'h0, 32'h3F800000, 32'h40400000});
        @(posedge clock);
        #1 chk("ign_idle", Busy, 0);
        @(posedge clock);
        #1 chk("ign_stay", Busy, 0);

        // Unhandled opcode leaves the block idle.
        issue(8'h44, 4'd0, 32'h40400000);
        chk("opc0_busy", Busy, 0);
        @(posedge clock);
        #1 chk("opc0_busy2", Busy, 0);

        // Load non-zero outputs, then reset in ADDSUB.
        run_op("pre_rst", 8'h55, 4'd9, 32'hC0000000,
               32'hBF800000, 32'hC0400000, 1'b1);
        issue(8'h66, 4'd5, 32'h40400000);
        @(posedge clock);
        #1 reset = 1'b0;
        #1 chk("rst_mid", {Busy, ProcessInputReady, InvalidOp,
                           InstructionPacket_Processed}, '0);
        @(negedge clock) reset = 1'b1;
        run_op("post_rst", 8'h77, 4'd9, 32'h3F000000,
               32'h3FC00000, 32'hBF000000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
